// File: rtl/dcp_io_arbiter.sv
// dcp_io_arbiter: shares one RX and one TX channel between N command units
//
// Two independent round-robin arbiters (one per channel). A grant is held for
// a whole req/ack transaction, then the priority pointer moves past the winner.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   req_rx/type_rx  [N]        per-unit RX request/type
//   ack_rx          [N]        per-unit RX ack (granted bit only)
//   req_tx/type_tx  [N]        per-unit TX request/type
//   dout            [N*DW]     per-unit TX data, unit i at [i*DW +: DW]
//   ack_tx          [N]        per-unit TX ack (granted bit only)
//   din_rx, flag_rx            RX data/flag broadcast from the rx unit
//   req_rx_o, type_rx_o        request/type to the rx unit
//   ack_rx_i, din_rx_i, flag_rx_i  from the rx unit
//   req_tx_o, type_tx_o, dout_o    request/type/data to the tx unit
//   ack_tx_i                   ack from the tx unit
//   gnt_rx, gnt_tx  [N]        one-hot grants, 0 when idle

module dcp_io_arb_ch #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic [N-1:0] type_i,
    input  logic         ack_i,
    output logic         req_o,
    output logic         type_o,
    output logic [N-1:0] ack,
    output logic [N-1:0] gnt
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d, pick, nxt;
    logic          active;

    // Walk offsets downward so the smallest offset from the pointer wins.
    always_comb begin
        pick = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr_q) + k) % N]) pick = IW'((int'(ptr_q) + k) % N);
    end

    assign nxt    = (int'(idx_q) == N - 1) ? '0 : idx_q + IW'(1);
    assign active = state_q != IDLE;
    assign req_o  = (state_q == BUSY) && req[idx_q];
    assign type_o = active && type_i[idx_q];
    assign gnt    = active ? N'(1) << idx_q : '0;
    assign ack    = (active && ack_i) ? N'(1) << idx_q : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (|req) begin
                idx_d   = pick;
                state_d = BUSY;
            end
            BUSY: if (ack_i) state_d = DONE;
                  else if (!req[idx_q]) begin
                      state_d = IDLE;
                      ptr_d   = nxt;
                  end
            default: if (!ack_i && !req[idx_q]) begin
                state_d = IDLE;
                ptr_d   = nxt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

module dcp_io_arbiter #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req_rx,
    input  logic [N-1:0]  type_rx,
    output logic [N-1:0]  ack_rx,
    input  logic [N-1:0]  req_tx,
    input  logic [N-1:0]  type_tx,
    input  logic [N*DW-1:0] dout,
    output logic [N-1:0]  ack_tx,
    output logic [DW-1:0] din_rx,
    output logic          flag_rx,
    output logic          req_rx_o,
    output logic          type_rx_o,
    input  logic          ack_rx_i,
    input  logic [DW-1:0] din_rx_i,
    input  logic          flag_rx_i,
    output logic          req_tx_o,
    output logic          type_tx_o,
    output logic [DW-1:0] dout_o,
    input  logic          ack_tx_i,
    output logic [N-1:0]  gnt_rx,
    output logic [N-1:0]  gnt_tx
);
    dcp_io_arb_ch #(.N(N)) u_rx (
        .clk(clk), .rstn(rstn), .req(req_rx), .type_i(type_rx), .ack_i(ack_rx_i),
        .req_o(req_rx_o), .type_o(type_rx_o), .ack(ack_rx), .gnt(gnt_rx)
    );

    dcp_io_arb_ch #(.N(N)) u_tx (
        .clk(clk), .rstn(rstn), .req(req_tx), .type_i(type_tx), .ack_i(ack_tx_i),
        .req_o(req_tx_o), .type_o(type_tx_o), .ack(ack_tx), .gnt(gnt_tx)
    );

    // One-hot grant makes an AND-OR mux sufficient; idle gives zero.
    always_comb begin
        dout_o = '0;
        for (int i = 0; i < N; i++)
            dout_o = dout_o | (gnt_tx[i] ? dout[i*DW +: DW] : '0);
    end

    assign din_rx  = din_rx_i;
    assign flag_rx = flag_rx_i;
endmodule
